// File: rtl/exception_pkg.sv
// Shared definitions for the commit-stage exception arbiter: ExcCode values,
// arbiter state encoding and the exception_info record handed to cp0.
package exception_pkg;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_ADEL = 5'd4;
    localparam logic [4:0] CODE_ADES = 5'd5;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_BP   = 5'd9;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        BLOCK  = 2'd2
    } exc_state_t;

    // Layout matches the exception_info bundle cp0 consumes.
    typedef struct packed {
        logic        valid;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        in_delay_slot;
        logic [31:0] badvaddr;
        logic [31:0] location;
    } exception_t;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for asynchronous interrupt lines.
module irq_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives a clean level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Commit-stage exception arbiter: qualifies interrupts, picks one exception
// by fixed priority, reports it to cp0 one cycle later and then flushes the
// wrong path until fetch confirms it has redirected.
//
// Handshake: the commit stage offers an instruction with inst_valid; it is
// consumed (accept) only in a cycle where stall=0 and the arbiter is IDLE.
// There is no back-pressure towards the stage beyond that: an instruction
// offered while REPORT/BLOCK is simply discarded (it is wrong-path).
module exception_unit
    import exception_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          N_EXT_INT  = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_EXT_INT-1:0] ext_int,
    input  logic                 inst_valid,
    input  logic                 stall,
    input  logic [31:0]          inst_pc,
    input  logic                 in_delay_slot,
    input  logic                 exc_if_adel,
    input  logic                 exc_ri,
    input  logic                 exc_ov,
    input  logic                 exc_sys,
    input  logic                 exc_bp,
    input  logic                 exc_mem_adel,
    input  logic                 exc_mem_ades,
    input  logic [31:0]          mem_addr,
    input  logic                 is_eret_in,
    input  logic                 status_ie,
    input  logic                 status_exl,
    input  logic [7:0]           status_im,
    input  logic [1:0]           cause_ip_sw,
    input  logic                 timer_interrupt,
    input  logic                 fetch_redirected,
    output logic                 kill,
    output logic                 exc_valid,
    output logic [4:0]           exc_code,
    output logic [31:0]          exc_pc,
    output logic                 exc_in_delay_slot,
    output logic [31:0]          exc_badvaddr,
    output logic [31:0]          exc_location,
    output logic                 is_eret,
    output logic                 flush,
    output logic [1:0]           dbg_state
);

    exc_state_t           state;
    exception_t           info;
    logic                 eret_q;
    logic [N_EXT_INT-1:0] ext_s;
    logic [7:0]           ip;
    logic                 int_req;
    logic                 accept;
    logic                 exc_any;
    logic [4:0]           sel_code;
    logic [31:0]          sel_bad;
    logic                 sel_is_addr;

    irq_sync #(.WIDTH(N_EXT_INT)) u_irq_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ext_int),
        .q      (ext_s)
    );

    // Timer shares the HW5 line, as on MIPS32 with IntCtl.IPTI = 7.
    assign ip      = {ext_s[5] | timer_interrupt, ext_s[4:0], cause_ip_sw};
    assign int_req = status_ie & ~status_exl & (|(ip & status_im));
    assign accept  = inst_valid & ~stall & (state == IDLE);

    // Fixed-priority pick; an interrupt rides on the accepted instruction.
    always_comb begin
        exc_any     = 1'b1;
        sel_code    = CODE_INT;
        sel_bad     = 32'h0;
        sel_is_addr = 1'b0;
        if (int_req) begin
            sel_code = CODE_INT;
        end else if (exc_if_adel) begin
            sel_code    = CODE_ADEL;
            sel_bad     = inst_pc;
            sel_is_addr = 1'b1;
        end else if (exc_ri) begin
            sel_code = CODE_RI;
        end else if (exc_ov) begin
            sel_code = CODE_OV;
        end else if (exc_sys) begin
            sel_code = CODE_SYS;
        end else if (exc_bp) begin
            sel_code = CODE_BP;
        end else if (exc_mem_adel) begin
            sel_code    = CODE_ADEL;
            sel_bad     = mem_addr;
            sel_is_addr = 1'b1;
        end else if (exc_mem_ades) begin
            sel_code    = CODE_ADES;
            sel_bad     = mem_addr;
            sel_is_addr = 1'b1;
        end else begin
            exc_any = 1'b0;
        end
    end

    // ERET is allowed to commit; anything that raises an exception is not.
    assign kill = accept & exc_any;

    // Report register: valid/eret pulse each accept, fields hold otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            info   <= '0;
            eret_q <= 1'b0;
        end else begin
            info.valid <= accept & exc_any;
            eret_q     <= accept & is_eret_in & ~exc_any;
            if (accept & exc_any) begin
                info.code          <= sel_code;
                info.pc            <= inst_pc;
                info.in_delay_slot <= in_delay_slot;
                info.location      <= EXC_VECTOR;
                if (sel_is_addr) begin
                    info.badvaddr <= sel_bad;
                end
            end
        end
    end

    // Redirect tracking: a redirect seen while reporting skips BLOCK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept & (exc_any | is_eret_in)) state <= REPORT;
                REPORT:  state <= fetch_redirected ? IDLE : BLOCK;
                BLOCK:   if (fetch_redirected) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign exc_valid         = info.valid;
    assign exc_code          = info.code;
    assign exc_pc            = info.pc;
    assign exc_in_delay_slot = info.in_delay_slot;
    assign exc_badvaddr      = info.badvaddr;
    assign exc_location      = info.location;
    assign is_eret           = eret_q;
    assign flush             = (state == REPORT) | (state == BLOCK);
    assign dbg_state         = state;

endmodule
